// File: rtl/oled_init_sequencer.sv
// SSD1331 PmodOLEDrgb power-up and init sequencer.
// Sequences power/reset pins, then streams the startup command ROM over valid/ready.
module oled_init_sequencer #(
    parameter int NUM_COMMANDS  = 25,
    parameter int VCC_CMD_INDEX = 24,
    parameter int PWR_DELAY     = 2_000_000,
    parameter int RES_CYCLES    = 300,
    parameter int VCC_DELAY     = 2_500_000,
    parameter int FINAL_DELAY   = 10_000_000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    output logic [4:0]   command_out,
    input  logic [3:0]   comm_length_in,
    input  logic [119:0] comm_data_in,
    output logic [7:0]   byte_out,
    output logic         byte_valid_out,
    input  logic         byte_ready_in,
    output logic         dc_out,
    output logic         res_n_out,
    output logic         vccen_out,
    output logic         pmoden_out,
    output logic         busy_out,
    output logic         done_out
);

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, RES_LOW, RES_HIGH, LOAD,
        SEND, NEXT, VCC_WAIT, FINAL_WAIT, DONE
    } state_t;

    localparam logic [31:0] PWR_LD   = 32'(PWR_DELAY - 1);
    localparam logic [31:0] RES_LD   = 32'(RES_CYCLES - 1);
    localparam logic [31:0] VCC_LD   = 32'(VCC_DELAY - 1);
    localparam logic [31:0] FINAL_LD = 32'(FINAL_DELAY - 1);
    localparam logic [4:0]  LAST_CMD = 5'(NUM_COMMANDS - 1);
    localparam logic [4:0]  VCC_CMD  = 5'(VCC_CMD_INDEX);

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [4:0]    cmd_q, cmd_d;
    logic [3:0]    len_q, len_d;
    logic [119:0]  data_q, data_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          res_n_q, res_n_d;
    logic          vccen_q, vccen_d;
    logic          pmoden_q, pmoden_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    nxt_idx;
    logic [119:0]  shifted;

    // Next byte is taken from the latched copy, MSB-first.
    assign nxt_idx = idx_q + 4'd1;
    assign shifted = data_q << {nxt_idx, 3'b000};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            res_n_q  <= 1'b1;
            vccen_q  <= 1'b0;
            pmoden_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            res_n_q  <= res_n_d;
            vccen_q  <= vccen_d;
            pmoden_q <= pmoden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        data_d   = data_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        res_n_d  = res_n_q;
        vccen_d  = vccen_q;
        pmoden_d = pmoden_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    state_d  = PWR_WAIT;
                    cnt_d    = PWR_LD;
                    pmoden_d = 1'b1;
                    vccen_d  = 1'b0;
                    res_n_d  = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            PWR_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d = RES_LOW;
                    cnt_d   = RES_LD;
                    res_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RES_LOW: begin
                if (cnt_q == 32'd0) begin
                    state_d = RES_HIGH;
                    cnt_d   = RES_LD;
                    res_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RES_HIGH: begin
                if (cnt_q == 32'd0) begin
                    state_d = LOAD;
                    cmd_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            LOAD: begin
                len_d  = comm_length_in;
                data_d = comm_data_in;
                idx_d  = 4'd0;
                if (comm_length_in == 4'd0) begin
                    state_d = NEXT;
                end else begin
                    state_d = SEND;
                    byte_d  = comm_data_in[119:112];
                    valid_d = 1'b1;
                end
            end
            SEND: begin
                if (valid_q && byte_ready_in) begin
                    if (idx_q == len_q - 4'd1) begin
                        valid_d = 1'b0;
                        state_d = NEXT;
                    end else begin
                        idx_d  = nxt_idx;
                        byte_d = shifted[119:112];
                    end
                end
            end
            NEXT: begin
                if (cmd_q == LAST_CMD) begin
                    state_d = FINAL_WAIT;
                    cnt_d   = FINAL_LD;
                end else if (cmd_q + 5'd1 == VCC_CMD) begin
                    state_d = VCC_WAIT;
                    cnt_d   = VCC_LD;
                    vccen_d = 1'b1;
                end else begin
                    state_d = LOAD;
                    cmd_d   = cmd_q + 5'd1;
                end
            end
            VCC_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d = LOAD;
                    cmd_d   = VCC_CMD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            FINAL_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign command_out    = cmd_q;
    assign byte_out       = byte_q;
    assign byte_valid_out = valid_q;
    assign dc_out         = 1'b0;
    assign res_n_out      = res_n_q;
    assign vccen_out      = vccen_q;
    assign pmoden_out     = pmoden_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer with an SSD1331 startup ROM model.
// Short delays keep the whole power-up sequence to a few hundred cycles.
module tb_oled_init_sequencer;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         start_in;
    logic [4:0]   command_out;
    logic [3:0]   comm_length_in;
    logic [119:0] comm_data_in;
    logic [7:0]   byte_out;
    logic         byte_valid_out;
    logic         byte_ready_in;
    logic         dc_out;
    logic         res_n_out;
    logic         vccen_out;
    logic         pmoden_out;
    logic         busy_out;
    logic         done_out;

    int checks = 0;
    int errors = 0;
    bit zero5 = 1'b0;
    bit rnd_mode = 1'b0;
    bit dc_bad = 1'b0;
    logic [7:0] got [$];

    always #5 clk = ~clk;

    oled_init_sequencer #(
        .NUM_COMMANDS(25),
        .VCC_CMD_INDEX(24),
        .PWR_DELAY(4),
        .RES_CYCLES(3),
        .VCC_DELAY(5),
        .FINAL_DELAY(6)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .start_in(start_in),
        .command_out(command_out),
        .comm_length_in(comm_length_in),
        .comm_data_in(comm_data_in),
        .byte_out(byte_out),
        .byte_valid_out(byte_valid_out),
        .byte_ready_in(byte_ready_in),
        .dc_out(dc_out),
        .res_n_out(res_n_out),
        .vccen_out(vccen_out),
        .pmoden_out(pmoden_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    // Startup ROM: flat byte stream plus per-entry lengths.
    logic [7:0] flat [51] = '{
        8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
        8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31,
        8'hB3, 8'hF0, 8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB,
        8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50,
        8'h83, 8'h7D, 8'h2E, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F,
        8'h25, 8'h00, 8'h00, 8'h5F, 8'h3F, 8'hAF
    };
    logic [3:0] rom_len [25] = '{
        4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
        4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
        4'd1, 4'd3, 4'd3, 4'd5, 4'd1
    };

    int         rom_off;
    logic [3:0] rom_l;

    always_comb begin
        rom_off = 0;
        rom_l = 4'd0;
        for (int i = 0; i < 25; i++) begin
            if (i < int'(command_out)) rom_off += int'(rom_len[i]);
            if (i == int'(command_out)) rom_l = rom_len[i];
        end
        if (zero5 && command_out == 5'd5) rom_l = 4'd0;
        comm_length_in = rom_l;
        comm_data_in = '0;
        for (int k = 0; k < 15; k++)
            if (k < int'(rom_l))
                comm_data_in[119-8*k -: 8] = flat[rom_off+k];
    end

    always @(negedge clk) begin
        if (byte_valid_out && byte_ready_in) got.push_back(byte_out);
        if (dc_out !== 1'b0) dc_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) byte_ready_in = ($urandom_range(0, 9) < 3);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_out !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check(tag, 32'(done_out), 1);
    endtask

    task automatic check_stream(input string tag, input int base,
                                input bit skip5);
        int n = 0;
        check({tag, "_count"}, 32'(got.size() - base), skip5 ? 50 : 51);
        for (int i = 0; i < 51; i++) begin
            if (!(skip5 && i == 9)) begin
                if (base + n < got.size())
                    check($sformatf("%s_b%0d", tag, n),
                          32'(got[base+n]), 32'(flat[i]));
                n++;
            end
        end
    endtask

    initial begin
        int base;
        int n;
        bit hold_ok;
        rst_in = 1'b1;
        start_in = 1'b0;
        byte_ready_in = 1'b1;
        step();
        step();
        check("rst_cmd", 32'(command_out), 0);
        check("rst_byte", 32'(byte_out), 0);
        check("rst_valid", 32'(byte_valid_out), 0);
        check("rst_dc", 32'(dc_out), 0);
        check("rst_res_n", 32'(res_n_out), 1);
        check("rst_vccen", 32'(vccen_out), 0);
        check("rst_pmoden", 32'(pmoden_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        rst_in = 1'b0;
        step();
        check("idle_pmoden", 32'(pmoden_out), 0);

        // Full sequence with ready tied high
        base = got.size();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("st_pmoden", 32'(pmoden_out), 1);
        check("st_busy", 32'(busy_out), 1);
        check("st_res_n", 32'(res_n_out), 1);
        repeat (3) step();
        check("pwr_res_n_hi", 32'(res_n_out), 1);
        step();
        check("res_low_first", 32'(res_n_out), 0);
        repeat (2) step();
        check("res_low_last", 32'(res_n_out), 0);
        step();
        check("res_high", 32'(res_n_out), 1);
        repeat (3) step();
        check("load0_cmd", 32'(command_out), 0);
        check("load0_valid", 32'(byte_valid_out), 0);
        step();
        check("first_valid", 32'(byte_valid_out), 1);
        check("first_byte", 32'(byte_out), 'hFD);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("busy_start_ign", 32'(busy_out), 1);
        check("second_byte", 32'(byte_out), 'h12);
        n = 0;
        while (vccen_out !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("vcc_rise", 32'(vccen_out), 1);
        check("pre_vcc_bytes", 32'(got.size() - base), 50);
        repeat (4) step();
        check("vcc_wait_cmd", 32'(command_out), 23);
        step();
        check("vcc_load_cmd", 32'(command_out), 24);
        check("vcc_load_valid", 32'(byte_valid_out), 0);
        step();
        check("af_valid", 32'(byte_valid_out), 1);
        check("af_byte", 32'(byte_out), 'hAF);
        repeat (7) step();
        check("final_wait_done", 32'(done_out), 0);
        step();
        check("done", 32'(done_out), 1);
        check("done_busy", 32'(busy_out), 0);
        check("done_vccen", 32'(vccen_out), 1);
        check("done_pmoden", 32'(pmoden_out), 1);
        check("done_cmd", 32'(command_out), 24);
        check_stream("full", base, 1'b0);

        // Restart from DONE with backpressure on command 21
        base = got.size();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("rs_done", 32'(done_out), 0);
        check("rs_vccen", 32'(vccen_out), 0);
        check("rs_busy", 32'(busy_out), 1);
        n = 0;
        while (!(command_out == 5'd21 && byte_valid_out === 1'b1 &&
                 byte_out == 8'h5F) && n < 1000) begin
            step();
            n++;
        end
        check("bp_reach", 32'(command_out), 21);
        byte_ready_in = 1'b0;
        hold_ok = 1'b1;
        repeat (7) begin
            step();
            if (byte_out !== 8'h5F || byte_valid_out !== 1'b1) hold_ok = 1'b0;
        end
        check("bp_hold", 32'(hold_ok), 1);
        byte_ready_in = 1'b1;
        wait_done("bp_done");
        check_stream("bp", base, 1'b0);

        // Random ready at 30% duty
        base = got.size();
        rnd_mode = 1'b1;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        wait_done("rnd_done");
        rnd_mode = 1'b0;
        byte_ready_in = 1'b1;
        check_stream("rnd", base, 1'b0);
        check("dc_low", 32'(dc_bad), 0);

        // Zero-length entry at index 5
        zero5 = 1'b1;
        base = got.size();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        n = 0;
        while (command_out != 5'd5 && n < 500) begin
            step();
            n++;
        end
        n = 0;
        while (command_out == 5'd5 && n < 10) begin
            step();
            n++;
        end
        check("zl_cycles", 32'(n), 2);
        check("zl_next_cmd", 32'(command_out), 6);
        wait_done("zl_done");
        check_stream("zl", base, 1'b1);
        zero5 = 1'b0;

        // Reset in the middle of command 12
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        n = 0;
        while (!(command_out == 5'd12 && byte_valid_out === 1'b1) &&
               n < 500) begin
            step();
            n++;
        end
        check("mr_reach", 32'(command_out), 12);
        rst_in = 1'b1;
        step();
        check("mr_valid", 32'(byte_valid_out), 0);
        check("mr_res_n", 32'(res_n_out), 1);
        check("mr_pmoden", 32'(pmoden_out), 0);
        check("mr_busy", 32'(busy_out), 0);
        check("mr_cmd", 32'(command_out), 0);
        rst_in = 1'b0;
        step();
        base = got.size();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        wait_done("mr_done");
        check_stream("replay", base, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
